// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding, load-use stall, flush and halt.
// Optional stall-cycle counter is built only when ID_EX_STALL_COUNT_EN is defined.
module id_ex_stage #(
  parameter int DATA_W = 16,
  parameter int REG_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic              in_halt,
  input  logic              in_write,
  input  logic [REG_W-1:0]  in_writeReg,
  input  logic [REG_W-1:0]  in_readReg0,
  input  logic [REG_W-1:0]  in_readReg1,
  input  logic              in_use0,
  input  logic              in_use1,
  input  logic [3:0]        in_ALU_operation,
  input  logic              in_ReadMem,
  input  logic              in_WriteMem,
  input  logic [1:0]        in_quarter,
  input  logic [DATA_W-1:0] in_readData0,
  input  logic [DATA_W-1:0] in_readData1,
  input  logic [DATA_W-1:0] in_dataToMem,
  input  logic              flush,
  input  logic              exmem_write,
  input  logic [REG_W-1:0]  exmem_writeReg,
  input  logic [DATA_W-1:0] exmem_data,
  input  logic              memwb_write,
  input  logic [REG_W-1:0]  memwb_writeReg,
  input  logic [DATA_W-1:0] memwb_data,
  output logic              stall,
  output logic              o_valid,
  output logic              o_write,
  output logic [REG_W-1:0]  o_writeReg,
  output logic [3:0]        o_ALU_operation,
  output logic              o_ReadMem,
  output logic              o_WriteMem,
  output logic [1:0]        o_quarter,
  output logic [DATA_W-1:0] o_readData0,
  output logic [DATA_W-1:0] o_readData1,
  output logic [DATA_W-1:0] o_dataToMem,
  output logic              o_halted,
  output logic [15:0]       stall_count
);

  typedef enum logic {RUN, HALTED} state_t;

  state_t            state, state_nxt;
  logic              hz;
  logic              capture;
  logic [1:0]        sel0, sel1;
  logic [DATA_W-1:0] fwd0, fwd1, fwd_mem;

  always_comb begin
    hz = in_valid & o_valid & o_ReadMem & o_write &
         ((in_use0 & (in_readReg0 == o_writeReg)) |
          (in_use1 & (in_readReg1 == o_writeReg)));
  end

  assign stall = hz & ~flush & (state == RUN);

  always_comb begin
    capture   = 1'b0;
    state_nxt = state;
    if (state == RUN) begin
      capture = in_valid & ~flush & ~stall;
      if (capture & in_halt) state_nxt = HALTED;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RUN;
    else       state <= state_nxt;
  end

  // sel: 2 = EX/MEM, 1 = MEM/WB, 0 = regfile; EX/MEM is the younger result and wins
  always_comb begin
    sel0 = 2'd0;
    if (in_use0) begin
      if (exmem_write && exmem_writeReg == in_readReg0)      sel0 = 2'd2;
      else if (memwb_write && memwb_writeReg == in_readReg0) sel0 = 2'd1;
    end
    sel1 = 2'd0;
    if (in_use1) begin
      if (exmem_write && exmem_writeReg == in_readReg1)      sel1 = 2'd2;
      else if (memwb_write && memwb_writeReg == in_readReg1) sel1 = 2'd1;
    end
  end

  always_comb begin
    case (sel0)
      2'd2:    fwd0 = exmem_data;
      2'd1:    fwd0 = memwb_data;
      default: fwd0 = in_readData0;
    endcase
    case (sel1)
      2'd2:    begin fwd1 = exmem_data; fwd_mem = exmem_data; end
      2'd1:    begin fwd1 = memwb_data; fwd_mem = memwb_data; end
      default: begin fwd1 = in_readData1; fwd_mem = in_dataToMem; end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_valid         <= 1'b0;
      o_write         <= 1'b0;
      o_writeReg      <= '0;
      o_ALU_operation <= '0;
      o_ReadMem       <= 1'b0;
      o_WriteMem      <= 1'b0;
      o_quarter       <= '0;
      o_readData0     <= '0;
      o_readData1     <= '0;
      o_dataToMem     <= '0;
      o_halted        <= 1'b0;
    end else begin
      if (capture) begin
        o_valid         <= 1'b1;
        o_write         <= in_write;
        o_writeReg      <= in_writeReg;
        o_ALU_operation <= in_ALU_operation;
        o_ReadMem       <= in_ReadMem;
        o_WriteMem      <= in_WriteMem;
        o_quarter       <= in_quarter;
        o_readData0     <= fwd0;
        o_readData1     <= fwd1;
        o_dataToMem     <= fwd_mem;
      end else begin
        o_valid         <= 1'b0;
        o_write         <= 1'b0;
        o_writeReg      <= '0;
        o_ALU_operation <= '0;
        o_ReadMem       <= 1'b0;
        o_WriteMem      <= 1'b0;
        o_quarter       <= '0;
        o_readData0     <= '0;
        o_readData1     <= '0;
        o_dataToMem     <= '0;
      end
      if (capture & in_halt) o_halted <= 1'b1;
    end
  end

`ifdef ID_EX_STALL_COUNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                               stall_count <= '0;
    else if (stall && stall_count != 16'hFFFF) stall_count <= stall_count + 16'd1;
  end
`else
  assign stall_count = 16'd0;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: a reference model pushes expected EX-side state per edge,
// popped and compared one edge later; includes directed forwarding, hazard, flush, halt and reset cases.
module tb_id_ex_stage;
  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_halt, in_write, in_use0, in_use1, in_ReadMem, in_WriteMem, flush;
  logic [3:0]  in_writeReg, in_readReg0, in_readReg1, in_ALU_operation;
  logic [1:0]  in_quarter;
  logic [15:0] in_readData0, in_readData1, in_dataToMem;
  logic        exmem_write, memwb_write;
  logic [3:0]  exmem_writeReg, memwb_writeReg;
  logic [15:0] exmem_data, memwb_data;
  logic        stall, o_valid, o_write, o_ReadMem, o_WriteMem, o_halted;
  logic [3:0]  o_writeReg, o_ALU_operation;
  logic [1:0]  o_quarter;
  logic [15:0] o_readData0, o_readData1, o_dataToMem, stall_count;

  id_ex_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_halt(in_halt), .in_write(in_write),
    .in_writeReg(in_writeReg), .in_readReg0(in_readReg0), .in_readReg1(in_readReg1),
    .in_use0(in_use0), .in_use1(in_use1), .in_ALU_operation(in_ALU_operation),
    .in_ReadMem(in_ReadMem), .in_WriteMem(in_WriteMem), .in_quarter(in_quarter),
    .in_readData0(in_readData0), .in_readData1(in_readData1), .in_dataToMem(in_dataToMem),
    .flush(flush), .exmem_write(exmem_write), .exmem_writeReg(exmem_writeReg),
    .exmem_data(exmem_data), .memwb_write(memwb_write), .memwb_writeReg(memwb_writeReg),
    .memwb_data(memwb_data), .stall(stall), .o_valid(o_valid), .o_write(o_write),
    .o_writeReg(o_writeReg), .o_ALU_operation(o_ALU_operation), .o_ReadMem(o_ReadMem),
    .o_WriteMem(o_WriteMem), .o_quarter(o_quarter), .o_readData0(o_readData0),
    .o_readData1(o_readData1), .o_dataToMem(o_dataToMem), .o_halted(o_halted),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid, write, rm, wm, halted;
    logic [3:0]  wreg, alu;
    logic [1:0]  q;
    logic [15:0] d0, d1, dm, scnt;
  } exp_t;

  exp_t m;
  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cmp(input exp_t e);
    check("o_valid", 32'(o_valid), 32'(e.valid));
    check("o_write", 32'(o_write), 32'(e.write));
    check("o_writeReg", 32'(o_writeReg), 32'(e.wreg));
    check("o_ALU_operation", 32'(o_ALU_operation), 32'(e.alu));
    check("o_ReadMem", 32'(o_ReadMem), 32'(e.rm));
    check("o_WriteMem", 32'(o_WriteMem), 32'(e.wm));
    check("o_quarter", 32'(o_quarter), 32'(e.q));
    check("o_readData0", 32'(o_readData0), 32'(e.d0));
    check("o_readData1", 32'(o_readData1), 32'(e.d1));
    check("o_dataToMem", 32'(o_dataToMem), 32'(e.dm));
    check("o_halted", 32'(o_halted), 32'(e.halted));
    check("stall_count", 32'(stall_count), 32'(e.scnt));
  endtask

  function automatic logic [15:0] fwd_m(input logic use_b, input logic [3:0] r, input logic [15:0] rf);
    if (!use_b) return rf;
    if (exmem_write && exmem_writeReg == r) return exmem_data;
    if (memwb_write && memwb_writeReg == r) return memwb_data;
    return rf;
  endfunction

  task automatic clr_in();
    in_valid = 0; in_halt = 0; in_write = 0; in_use0 = 0; in_use1 = 0;
    in_ReadMem = 0; in_WriteMem = 0; flush = 0;
    in_writeReg = 0; in_readReg0 = 0; in_readReg1 = 0; in_ALU_operation = 0; in_quarter = 0;
    in_readData0 = 0; in_readData1 = 0; in_dataToMem = 0;
    exmem_write = 0; memwb_write = 0; exmem_writeReg = 0; memwb_writeReg = 0;
    exmem_data = 0; memwb_data = 0;
  endtask

  // Called at a negedge with inputs already driven; returns at the following negedge.
  task automatic step();
    exp_t e;
    logic hz, es, cap;
    #1;
    hz = in_valid & m.valid & m.rm & m.write &
         ((in_use0 && in_readReg0 == m.wreg) || (in_use1 && in_readReg1 == m.wreg));
    es  = hz & ~flush & ~m.halted;
    check("stall", 32'(stall), 32'(es));
    cap = ~m.halted & ~flush & ~es & in_valid;
    e = '0;
    e.halted = m.halted;
    e.scnt   = m.scnt;
    if (cap) begin
      e.valid = 1; e.write = in_write; e.wreg = in_writeReg; e.alu = in_ALU_operation;
      e.rm = in_ReadMem; e.wm = in_WriteMem; e.q = in_quarter;
      e.d0 = fwd_m(in_use0, in_readReg0, in_readData0);
      e.d1 = fwd_m(in_use1, in_readReg1, in_readData1);
      e.dm = fwd_m(in_use1, in_readReg1, in_dataToMem);
      if (in_halt) e.halted = 1;
    end
`ifdef ID_EX_STALL_COUNT_EN
    if (es && e.scnt != 16'hFFFF) e.scnt = e.scnt + 16'd1;
`endif
    sb.push_back(e);
    m = e;
    @(posedge clk);
    #1;
    cmp(sb.pop_front());
    @(negedge clk);
  endtask

  // Asserts reset between edges and checks outputs clear without waiting for a clock.
  task automatic mid_reset();
    #2;
    reset = 1;
    #1;
    m = '0;
    cmp(m);
    check("stall_in_reset", 32'(stall), 32'd0);
    @(negedge clk);
    reset = 0;
  endtask

  initial begin
    clr_in();
    m = '0;
    reset = 1;
    @(negedge clk);
    #1;
    cmp(m);
    @(negedge clk);
    reset = 0;

    // plain capture
    in_valid = 1; in_ALU_operation = 4'h3; in_write = 1; in_writeReg = 5;
    in_readReg0 = 1; in_use0 = 1; in_readData0 = 16'h0012; in_quarter = 2'd2;
    step();

    // forwarding priority, then MEM/WB only
    clr_in();
    in_valid = 1; in_readReg0 = 2; in_use0 = 1; in_readData0 = 16'h0000;
    exmem_write = 1; exmem_writeReg = 2; exmem_data = 16'hAAAA;
    memwb_write = 1; memwb_writeReg = 2; memwb_data = 16'hBBBB;
    step();
    exmem_write = 0;
    step();
    // use bit clear: regfile value kept despite a matching writer
    in_use0 = 0; in_readData0 = 16'h5A5A;
    step();

    // load-use on r4 through source 1
    clr_in();
    in_valid = 1; in_ReadMem = 1; in_write = 1; in_writeReg = 4;
    step();
    clr_in();
    in_valid = 1; in_readReg1 = 4; in_use1 = 1; in_readData1 = 16'h1111;
    in_dataToMem = 16'h2222; in_WriteMem = 1; in_ALU_operation = 4'h7;
    step();
    exmem_write = 1; exmem_writeReg = 4; exmem_data = 16'h00C3;
    step();

    // flush wins over a pending hazard
    clr_in();
    in_valid = 1; in_ReadMem = 1; in_write = 1; in_writeReg = 4;
    step();
    clr_in();
    in_valid = 1; in_readReg0 = 4; in_use0 = 1; flush = 1;
    step();

    // randomized traffic over a small register range to hit hazards and forwarding
    for (int i = 0; i < 300; i++) begin
      in_valid = ($urandom_range(0, 7) != 0);
      in_halt = 0;
      in_write = $urandom_range(0, 1);
      in_writeReg = 4'($urandom_range(0, 3));
      in_readReg0 = 4'($urandom_range(0, 3));
      in_readReg1 = 4'($urandom_range(0, 3));
      in_use0 = $urandom_range(0, 1);
      in_use1 = $urandom_range(0, 1);
      in_ALU_operation = 4'($urandom);
      in_ReadMem = ($urandom_range(0, 2) == 0);
      in_WriteMem = $urandom_range(0, 1);
      in_quarter = 2'($urandom);
      in_readData0 = 16'($urandom);
      in_readData1 = 16'($urandom);
      in_dataToMem = 16'($urandom);
      flush = ($urandom_range(0, 7) == 0);
      exmem_write = $urandom_range(0, 1);
      exmem_writeReg = 4'($urandom_range(0, 3));
      exmem_data = 16'($urandom);
      memwb_write = $urandom_range(0, 1);
      memwb_writeReg = 4'($urandom_range(0, 3));
      memwb_data = 16'($urandom);
      step();
    end

    // halt, then five valid instructions that must all become bubbles
    clr_in();
    in_valid = 1; in_halt = 1;
    step();
    in_halt = 0; in_ReadMem = 1; in_write = 1; in_writeReg = 3; in_use0 = 1; in_readReg0 = 3;
    for (int i = 0; i < 5; i++) begin
      in_ALU_operation = 4'(i + 1);
      step();
    end

    // reset while halted with a writing halt instruction sitting in EX
    mid_reset();
    clr_in();
    in_valid = 1; in_halt = 1; in_write = 1; in_writeReg = 7;
    step();
    mid_reset();
    clr_in();
    in_valid = 1; in_ALU_operation = 4'h9; in_write = 1; in_writeReg = 6;
    in_readData0 = 16'h0BEE; in_readData1 = 16'h0CAB;
    step();

    if (sb.size() != 0) check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
